png_zlib_wrap: RTL and testbench
================================

Name: png_zlib_wrap

Overview:
Wraps a raw DEFLATE byte stream into a zlib stream (RFC 1950) for PNG IDAT payload. Sequence: 2-byte header (CMF, FLG), deflate bytes passed through, then the 4-byte big-endian Adler-32 trailer. The trailer value comes from png_adler32, which runs on the uncompressed filtered scanline bytes. This block also issues that block's init pulse. Sits between the deflate encoder (upstream) and the IDAT chunk packer (downstream).

Parameters:
WINDOW_LOG, 15, LZ77 window log2, range 8..15; CMF = ((WINDOW_LOG-8)<<4) | 8
FLEVEL, 0, zlib FLEVEL field, range 0..3; FLG = (FLEVEL<<6) | FCHECK, FDICT=0
FCHECK: elaboration-time constant chosen so that (CMF*256+FLG) mod 31 == 0

Ports:
clk  input  1  global clock
rstn  input  1  asynchronous reset, active low
zlib_start  input  1  start a stream; accepted only in IDLE
zlib_abort  input  1  synchronous abort, any state
adler32_init  output  1  one-cycle pulse to png_adler32 when zlib_start is accepted
adler32_in  input  32  Adler-32 value from png_adler32
adler32_fin  input  1  pulse: adler32_in is final for this stream
def_data  input  8  deflate byte
def_vld  input  1  deflate byte valid
def_last  input  1  qualifies the final deflate byte
def_rdy  output  1  block accepts def_data
zlib_data  output  8  zlib stream byte
zlib_vld  output  1  zlib byte valid
zlib_last  output  1  qualifies the final trailer byte
zlib_rdy  input  1  downstream accepts the byte
zlib_busy  output  1  high in every state except IDLE
zlib_done  output  1  one-cycle pulse after the last trailer byte is transferred

Behaviour:
- Reset values: all outputs 0; state IDLE; adler latch 0; flag adl_got 0.
- Output transfer occurs when zlib_vld && zlib_rdy. zlib_data, zlib_vld and zlib_last are registered. They are held stable while zlib_vld=1 and zlib_rdy=0.
- The output register may load when !zlib_vld || zlib_rdy (load_ok).
- FSM states: IDLE, HDR0, HDR1, DATA, WAIT_ADL, TRL, DONE.
- IDLE: on zlib_start, pulse adler32_init, clear adl_got, go to HDR0.
- HDR0: when load_ok, load CMF and go to HDR1.
- HDR1: when load_ok, load FLG and go to DATA.
- DATA: def_rdy = load_ok (combinational); def_rdy is 0 in all other states. On a deflate transfer (def_vld && def_rdy), load def_data.
  - If def_last is high on that transfer, go to TRL if adl_got (or adler32_fin is high this cycle); otherwise go to WAIT_ADL.
- WAIT_ADL: no output loads. Go to TRL in the cycle after adl_got is set.
- TRL: a 2-bit byte counter drives loads of adler[31:24], [23:16], [15:8], [7:0], one per load_ok. zlib_last is set together with byte 3. Go to DONE when byte 3 is loaded.
- DONE: wait for the transfer of the zlib_last byte, then pulse zlib_done and go to IDLE.
- Adler latch: in any non-IDLE state, adler32_fin captures adler32_in and sets adl_got. A later adler32_fin in the same stream overwrites the latch (last one wins). adler32_fin in IDLE is ignored.
- zlib_start while busy: ignored.
- zlib_abort: next cycle state is IDLE, zlib_vld and zlib_last are 0, adl_got is 0, and no zlib_done pulse is issued. If zlib_start and zlib_abort are high together in IDLE, abort wins.
- Empty deflate stream (zero bytes) is not supported; upstream always sends at least one byte with def_last.
- Asynchronous reset mid-stream: returns immediately to reset values.
- Throughput: 1 byte/cycle with zlib_rdy held high. Latency from a deflate byte transfer to zlib_vld is 1 cycle.

Optional Feature:
PNG_ZLIB_BYTE_CNT_EN:
- Defined: adds output zlib_byte_cnt[31:0]. It clears on accepted zlib_start and increments on every output transfer. It holds its value after zlib_done for use as the IDAT length field. Reset value 0.
- Undefined: the port and counter are absent.

Decomposition:
- Shared package png_pkg holds: state encoding localparams, ZLIB_CM_DEFLATE=8, the ADLER_MOD=65521 constant (shared with png_adler32), and the FCHECK constant function.
- No sub-module; the single FSM plus output register is natural. png_adler32 is instantiated beside this block at the PNG top level, not inside it.

Test Plan:
- Raw "a", deflate 4B 04 00, adler32_fin with 0x00620062 during DATA, zlib_rdy=1 -> output 78 01 4B 04 00 00 62 00 62, zlib_last on the 9th byte, zlib_done 1 cycle later.
- Same stream but adler32_fin issued 5 cycles after def_last -> FSM waits in WAIT_ADL with no zlib_vld, then emits trailer 00 62 00 62.
- zlib_rdy toggled 1/0 every cycle -> identical byte sequence, zlib_data stable while stalled, def_rdy=0 while stalled with zlib_vld=1.
- FLEVEL=2, WINDOW_LOG=15 -> header 78 9C; FLEVEL=0, WINDOW_LOG=8 -> header 08 1D.
- zlib_abort asserted after the 2nd deflate byte -> IDLE next cycle, zlib_vld=0, no zlib_done. A new zlib_start then produces a clean header 78 01 and an adler32_init pulse.
- With PNG_ZLIB_BYTE_CNT_EN and the first scenario -> zlib_byte_cnt=9 after zlib_done.

Source files
------------

// File: rtl/png_pkg.sv
// Shared PNG encoder definitions: zlib wrapper state encoding, zlib header
// constants, the Adler-32 modulus and the FCHECK helper.
package png_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR0     = 3'd1,
        ST_HDR1     = 3'd2,
        ST_DATA     = 3'd3,
        ST_WAIT_ADL = 3'd4,
        ST_TRL      = 3'd5,
        ST_DONE     = 3'd6
    } zlib_state_t;

    localparam logic [3:0]  ZLIB_CM_DEFLATE = 4'd8;
    localparam int unsigned ADLER_MOD       = 65521;

    // FCHECK makes the big-endian 16-bit header word a multiple of 31 (FDICT = 0).
    function automatic logic [4:0] zlib_fcheck(input logic [7:0] cmf, input logic [1:0] flevel);
        int unsigned rem;
        rem = (32'(cmf) * 32'd256 + 32'(flevel) * 32'd64) % 32'd31;
        return 5'((32'd31 - rem) % 32'd31);
    endfunction

endpackage

// File: rtl/png_zlib_wrap.sv
// Wraps a raw DEFLATE byte stream into a zlib stream: CMF/FLG header, deflate
// bytes, big-endian Adler-32 trailer. Optional macro PNG_ZLIB_BYTE_CNT_EN adds
// an output byte counter (zlib_byte_cnt) for the IDAT length field.
module png_zlib_wrap
    import png_pkg::*;
#(
    parameter int WINDOW_LOG = 15,
    parameter int FLEVEL     = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        zlib_start,
    input  logic        zlib_abort,
    output logic        adler32_init,
    input  logic [31:0] adler32_in,
    input  logic        adler32_fin,
    input  logic [7:0]  def_data,
    input  logic        def_vld,
    input  logic        def_last,
    output logic        def_rdy,
    output logic [7:0]  zlib_data,
    output logic        zlib_vld,
    output logic        zlib_last,
    input  logic        zlib_rdy,
    output logic        zlib_busy,
    output logic        zlib_done,
    output logic [2:0]  dbg_state
`ifdef PNG_ZLIB_BYTE_CNT_EN
    ,
    output logic [31:0] zlib_byte_cnt
`endif
);

    localparam logic [7:0] CMF = {4'(WINDOW_LOG - 8), ZLIB_CM_DEFLATE};
    localparam logic [7:0] FLG = {2'(FLEVEL), 1'b0, zlib_fcheck(CMF, 2'(FLEVEL))};

    // Handshakes: a byte moves when valid && ready in the same cycle; a source
    // holds data and valid stable until then. def_rdy is combinational.
    zlib_state_t r_state;
    zlib_state_t w_next_state;

    logic [7:0]  r_data;
    logic        r_vld;
    logic        r_last;
    logic [31:0] r_adler;
    logic        r_adl_got;
    logic [1:0]  r_trl_idx;
    logic        r_init;
    logic        r_done;

    logic        w_load_ok;
    logic        w_load;
    logic [7:0]  w_load_byte;
    logic        w_load_last;
    logic        w_init;
    logic        w_done;

    assign w_load_ok = !r_vld || zlib_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_byte  = 8'h00;
        w_load_last  = 1'b0;
        w_init       = 1'b0;
        w_done       = 1'b0;
        def_rdy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (zlib_start) begin
                    w_init       = 1'b1;
                    w_next_state = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (w_load_ok) begin
                    w_load       = 1'b1;
                    w_load_byte  = CMF;
                    w_next_state = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (w_load_ok) begin
                    w_load       = 1'b1;
                    w_load_byte  = FLG;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                def_rdy = w_load_ok;
                if (def_vld && w_load_ok) begin
                    w_load      = 1'b1;
                    w_load_byte = def_data;
                    if (def_last) begin
                        // A final Adler value arriving alongside def_last is latched this edge.
                        w_next_state = (r_adl_got || adler32_fin) ? ST_TRL : ST_WAIT_ADL;
                    end
                end
            end
            ST_WAIT_ADL: begin
                if (r_adl_got) begin
                    w_next_state = ST_TRL;
                end
            end
            ST_TRL: begin
                if (w_load_ok) begin
                    w_load = 1'b1;
                    case (r_trl_idx)
                        2'd0:    w_load_byte = r_adler[31:24];
                        2'd1:    w_load_byte = r_adler[23:16];
                        2'd2:    w_load_byte = r_adler[15:8];
                        default: w_load_byte = r_adler[7:0];
                    endcase
                    if (r_trl_idx == 2'd3) begin
                        w_load_last  = 1'b1;
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (r_vld && r_last && zlib_rdy) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (zlib_abort) begin
            w_next_state = ST_IDLE;
            w_load       = 1'b0;
            w_init       = 1'b0;
            w_done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data    <= 8'h00;
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_adler   <= 32'h0;
            r_adl_got <= 1'b0;
            r_trl_idx <= 2'd0;
            r_init    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_init <= w_init;
            r_done <= w_done;
            if (zlib_abort) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
            end else if (w_load) begin
                r_vld  <= 1'b1;
                r_data <= w_load_byte;
                r_last <= w_load_last;
            end else if (zlib_rdy) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
            end
            if (r_state != ST_TRL) begin
                r_trl_idx <= 2'd0;
            end else if (w_load) begin
                r_trl_idx <= r_trl_idx + 2'd1;
            end
            // Last adler32_fin within a stream wins; IDLE ignores it.
            if (zlib_abort || w_init) begin
                r_adl_got <= 1'b0;
            end else if (r_state != ST_IDLE && adler32_fin) begin
                r_adler   <= adler32_in;
                r_adl_got <= 1'b1;
            end
        end
    end

`ifdef PNG_ZLIB_BYTE_CNT_EN
    logic [31:0] r_byte_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byte_cnt <= 32'h0;
        end else if (w_init) begin
            r_byte_cnt <= 32'h0;
        end else if (r_vld && zlib_rdy) begin
            r_byte_cnt <= r_byte_cnt + 32'd1;
        end
    end

    assign zlib_byte_cnt = r_byte_cnt;
`endif

    assign zlib_data    = r_data;
    assign zlib_vld     = r_vld;
    assign zlib_last    = r_last;
    assign adler32_init = r_init;
    assign zlib_done    = r_done;
    assign zlib_busy    = (r_state != ST_IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_png_zlib_wrap.sv
// Self-checking bench for png_zlib_wrap: randomized streams against a
// queue-based zlib framing model, plus directed literal streams.
`timescale 1ns/1ps
module tb_png_zlib_wrap;
    import png_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        zlib_start = 1'b0;
    logic        zlib_abort = 1'b0;
    logic [31:0] adler32_in = 32'h0;
    logic        adler32_fin = 1'b0;
    logic [7:0]  def_data = 8'h00;
    logic        def_vld = 1'b0;
    logic        def_last = 1'b0;
    logic        zlib_rdy = 1'b0;

    logic        adler32_init, def_rdy, zlib_vld, zlib_last, zlib_busy, zlib_done;
    logic [7:0]  zlib_data;
    logic [2:0]  dbg_state;
    logic        b_init, b_def_rdy, b_vld, b_last, b_busy, b_done;
    logic [7:0]  b_data;
    logic [2:0]  b_state;
    logic        c_init, c_def_rdy, c_vld, c_last, c_busy, c_done;
    logic [7:0]  c_data;
    logic [2:0]  c_state;
`ifdef PNG_ZLIB_BYTE_CNT_EN
    logic [31:0] zlib_byte_cnt, b_byte_cnt, c_byte_cnt;
`endif

    always #5 clk = ~clk;

    png_zlib_wrap #(.WINDOW_LOG(15), .FLEVEL(0)) dut (
        .clk(clk), .rstn(rstn), .zlib_start(zlib_start), .zlib_abort(zlib_abort),
        .adler32_init(adler32_init), .adler32_in(adler32_in), .adler32_fin(adler32_fin),
        .def_data(def_data), .def_vld(def_vld), .def_last(def_last), .def_rdy(def_rdy),
        .zlib_data(zlib_data), .zlib_vld(zlib_vld), .zlib_last(zlib_last), .zlib_rdy(zlib_rdy),
        .zlib_busy(zlib_busy), .zlib_done(zlib_done), .dbg_state(dbg_state)
`ifdef PNG_ZLIB_BYTE_CNT_EN
        , .zlib_byte_cnt(zlib_byte_cnt)
`endif
    );

    png_zlib_wrap #(.WINDOW_LOG(15), .FLEVEL(2)) dut_b (
        .clk(clk), .rstn(rstn), .zlib_start(zlib_start), .zlib_abort(zlib_abort),
        .adler32_init(b_init), .adler32_in(adler32_in), .adler32_fin(adler32_fin),
        .def_data(def_data), .def_vld(def_vld), .def_last(def_last), .def_rdy(b_def_rdy),
        .zlib_data(b_data), .zlib_vld(b_vld), .zlib_last(b_last), .zlib_rdy(zlib_rdy),
        .zlib_busy(b_busy), .zlib_done(b_done), .dbg_state(b_state)
`ifdef PNG_ZLIB_BYTE_CNT_EN
        , .zlib_byte_cnt(b_byte_cnt)
`endif
    );

    png_zlib_wrap #(.WINDOW_LOG(8), .FLEVEL(0)) dut_c (
        .clk(clk), .rstn(rstn), .zlib_start(zlib_start), .zlib_abort(zlib_abort),
        .adler32_init(c_init), .adler32_in(adler32_in), .adler32_fin(adler32_fin),
        .def_data(def_data), .def_vld(def_vld), .def_last(def_last), .def_rdy(c_def_rdy),
        .zlib_data(c_data), .zlib_vld(c_vld), .zlib_last(c_last), .zlib_rdy(zlib_rdy),
        .zlib_busy(c_busy), .zlib_done(c_done), .dbg_state(c_state)
`ifdef PNG_ZLIB_BYTE_CNT_EN
        , .zlib_byte_cnt(c_byte_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Header word found by search: smallest FCHECK making the word divisible by 31.
    function automatic logic [15:0] model_header(input int wlog, input int flevel);
        int cmf;
        int flg;
        cmf = (wlog - 8) * 16 + 8;
        for (int f = 0; f < 32; f++) begin
            flg = flevel * 64 + f;
            if (((cmf * 256 + flg) % 31) == 0) return 16'(cmf * 256 + flg);
        end
        return 16'hFFFF;
    endfunction

    function automatic logic [31:0] adler_of_byte(input logic [7:0] b);
        int unsigned a;
        int unsigned s;
        a = (1 + 32'(b)) % ADLER_MOD;
        s = a % ADLER_MOD;
        return {s[15:0], a[15:0]};
    endfunction

    // ---------------- downstream ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       zlib_rdy = 1'b1;
            1:       zlib_rdy = ~zlib_rdy;
            default: zlib_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard / model ----------------
    logic [8:0]  exp_q[$];
    logic [7:0]  log_q[$];
    logic [7:0]  hb[2];
    logic [7:0]  hc[2];
    bit          m_active, m_adl_known, m_last_seen, m_trl_pushed;
    logic [31:0] m_adler;
    int unsigned m_byte_cnt;
    int          hdr_idx;
    bit          exp_init, exp_done, prev_stall, prev_def_xfer;
    logic [7:0]  prev_data;
    logic        prev_last;

    task automatic push_trailer();
        exp_q.push_back({1'b0, m_adler[31:24]});
        exp_q.push_back({1'b0, m_adler[23:16]});
        exp_q.push_back({1'b0, m_adler[15:8]});
        exp_q.push_back({1'b1, m_adler[7:0]});
        m_trl_pushed = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [8:0]  e;
        logic [15:0] h;
        bit          was_active;
        if (!rstn) begin
            exp_q.delete();
            m_active = 0; m_adl_known = 0; m_last_seen = 0; m_trl_pushed = 0;
            exp_init = 0; exp_done = 0; prev_stall = 0; prev_def_xfer = 0;
            hdr_idx = 2; m_byte_cnt = 0;
        end else begin
            was_active = m_active;
            check("adler32_init", {31'd0, adler32_init}, {31'd0, exp_init});
            check("zlib_done", {31'd0, zlib_done}, {31'd0, exp_done});
            check("zlib_busy", {31'd0, zlib_busy}, {31'd0, m_active});
`ifdef PNG_ZLIB_BYTE_CNT_EN
            if (exp_done) check("byte_cnt", zlib_byte_cnt, m_byte_cnt);
`endif
            if (prev_stall) begin
                check("stall_vld", {31'd0, zlib_vld}, 32'd1);
                check("stall_data", {24'd0, zlib_data}, {24'd0, prev_data});
                check("stall_last", {31'd0, zlib_last}, {31'd0, prev_last});
            end
            if (prev_def_xfer) check("latency_vld", {31'd0, zlib_vld}, 32'd1);
            if (zlib_vld && !zlib_rdy) check("def_rdy_stall", {31'd0, def_rdy}, 32'd0);
            exp_init = 0;
            exp_done = 0;

            if (zlib_vld && zlib_rdy) begin
                log_q.push_back(zlib_data);
                m_byte_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %h expected none at %0t", zlib_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("zlib_data", {24'd0, zlib_data}, {24'd0, e[7:0]});
                    check("zlib_last", {31'd0, zlib_last}, {31'd0, e[8]});
                    if (hdr_idx < 2) begin
                        h = model_header(15, 2);
                        check("hdr_flevel2", {24'd0, b_data}, {24'd0, (hdr_idx == 0) ? h[15:8] : h[7:0]});
                        h = model_header(8, 0);
                        check("hdr_wlog8", {24'd0, c_data}, {24'd0, (hdr_idx == 0) ? h[15:8] : h[7:0]});
                        hb[hdr_idx] = b_data;
                        hc[hdr_idx] = c_data;
                        hdr_idx++;
                    end
                    if (e[8]) begin
                        m_active = 0;
                        exp_done = !zlib_abort;
                    end
                end
            end
            prev_stall = zlib_vld && !zlib_rdy && !zlib_abort;
            prev_data  = zlib_data;
            prev_last  = zlib_last;

            if (zlib_abort) begin
                exp_q.delete();
                m_active = 0;
            end else begin
                if (was_active && adler32_fin) begin
                    m_adler = adler32_in;
                    m_adl_known = 1;
                    if (m_last_seen && !m_trl_pushed) push_trailer();
                end
                if (was_active && def_vld && def_rdy) begin
                    exp_q.push_back({1'b0, def_data});
                    if (def_last) begin
                        m_last_seen = 1;
                        if (m_adl_known) push_trailer();
                    end
                end
                if (!was_active && zlib_start) begin
                    h = model_header(15, 0);
                    exp_q.push_back({1'b0, h[15:8]});
                    exp_q.push_back({1'b0, h[7:0]});
                    m_active = 1; m_adl_known = 0; m_last_seen = 0; m_trl_pushed = 0;
                    m_byte_cnt = 0; hdr_idx = 0;
                    exp_init = 1;
                end
            end
            prev_def_xfer = def_vld && def_rdy && !zlib_abort;
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] stim[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit ok;
        int budget;
        ok = 0;
        budget = 0;
        def_data = d; def_vld = 1'b1; def_last = last;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = def_rdy;
            tick();
            budget++;
        end
        def_vld = 1'b0; def_last = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL def_handshake: got timeout expected def_rdy at %0t", $time);
        end
    endtask

    task automatic pulse_fin(input logic [31:0] v);
        adler32_in = v; adler32_fin = 1'b1;
        tick();
        adler32_fin = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        int budget;
        seen = 0;
        budget = 0;
        while (!seen && budget < 400) begin
            @(negedge clk);
            seen = zlib_done;
            budget++;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no zlib_done expected pulse at %0t", $time);
        end
        tick();
    endtask

    // fin_mode 0: fin after first byte; 1: fin 5 cycles after def_last; 2: two fins, last wins.
    task automatic run_stream(input int n, input logic [31:0] adl, input int fin_mode, input int abort_after);
        zlib_start = 1'b1;
        tick();
        zlib_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_byte(stim[i], (i == n - 1));
            if (i + 1 == abort_after) begin
                zlib_abort = 1'b1;
                tick();
                zlib_abort = 1'b0;
                @(negedge clk);
                check("abort_vld", {31'd0, zlib_vld}, 32'd0);
                check("abort_busy", {31'd0, zlib_busy}, 32'd0);
                repeat (4) tick();
                return;
            end
            if (i == 0 && fin_mode == 0) pulse_fin(adl);
            if (i == 0 && fin_mode == 2) begin
                pulse_fin(~adl);
                pulse_fin(adl);
            end
        end
        if (fin_mode == 1) begin
            repeat (5) tick();
            pulse_fin(adl);
        end
        wait_done();
    endtask

    task automatic check_literal_log(input string name);
        logic [7:0] lit[9];
        lit = '{8'h78, 8'h01, 8'h4B, 8'h04, 8'h00, 8'h00, 8'h62, 8'h00, 8'h62};
        check({name, "_len"}, 32'(log_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_q.size(); i++) begin
            check(name, {24'd0, log_q[i]}, {24'd0, lit[i]});
        end
    endtask

    task automatic load_a_stream();
        stim[0] = 8'h4B; stim[1] = 8'h04; stim[2] = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", {31'd0, zlib_vld}, 32'd0);
        check("rst_data", {24'd0, zlib_data}, 32'd0);
        check("rst_last", {31'd0, zlib_last}, 32'd0);
        check("rst_def_rdy", {31'd0, def_rdy}, 32'd0);
        check("rst_busy", {31'd0, zlib_busy}, 32'd0);
        check("rst_done", {31'd0, zlib_done}, 32'd0);
        check("rst_init", {31'd0, adler32_init}, 32'd0);
        rstn = 1'b1;
        repeat (2) tick();
        check("model_adler_a", adler_of_byte(8'h61), 32'h00620062);

        // Raw "a": fin during DATA, fin after def_last, stalled downstream.
        load_a_stream();
        rdy_mode = 0;
        log_q.delete();
        run_stream(3, 32'h00620062, 0, 0);
        check_literal_log("stream_a");
        check("hdr_b0", {24'd0, hb[0]}, 32'h78);
        check("hdr_b1", {24'd0, hb[1]}, 32'h9C);
        check("hdr_c0", {24'd0, hc[0]}, 32'h08);
        check("hdr_c1", {24'd0, hc[1]}, 32'h1D);
`ifdef PNG_ZLIB_BYTE_CNT_EN
        check("byte_cnt_a", zlib_byte_cnt, 32'd9);
`endif
        log_q.delete();
        run_stream(3, 32'h00620062, 1, 0);
        check_literal_log("stream_a_wait");
        rdy_mode = 1;
        log_q.delete();
        run_stream(3, 32'h00620062, 0, 0);
        check_literal_log("stream_a_stall");

        // Abort after the second deflate byte, then a clean restart.
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) stim[i] = 8'($urandom_range(0, 255));
        run_stream(5, 32'hDEADBEEF, 0, 2);
        load_a_stream();
        log_q.delete();
        run_stream(3, 32'h00620062, 2, 0);
        check_literal_log("stream_after_abort");

        // Randomized streams.
        for (int s = 0; s < 24; s++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) stim[i] = 8'($urandom_range(0, 255));
            rdy_mode = $urandom_range(0, 2);
            run_stream(n, $urandom, $urandom_range(0, 2), 0);
        end

        // Asynchronous reset mid-stream, then recovery.
        rdy_mode = 0;
        zlib_start = 1'b1;
        tick();
        zlib_start = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_vld", {31'd0, zlib_vld}, 32'd0);
        check("arst_busy", {31'd0, zlib_busy}, 32'd0);
        check("arst_data", {24'd0, zlib_data}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        load_a_stream();
        log_q.delete();
        run_stream(3, 32'h00620062, 0, 0);
        check_literal_log("stream_after_reset");

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
